filter_window_sequencer: RTL
============================

FILTER_WINDOW_SEQUENCER -- requirements
Module: filter_window_sequencer

Interface
REQ-001 Parameter GAMMA_CYCLE_WIDTH, default 16, SHALL be the number of aclk ticks in one gamma cycle's compute window; legal range 2 to 256.
REQ-002 Derived constant CW = $clog2(GAMMA_CYCLE_WIDTH) SHALL set the width of every tick-valued port.
REQ-003 aclk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 grst  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 en  in  1  SHALL request continuous gamma-cycle operation.
REQ-006 cfg_valid  in  1  SHALL qualify a window configuration offer.
REQ-007 cfg_lo  in  CW  SHALL be the lower edge-time bound, meaning the tick at which sel_greater rises.
REQ-008 cfg_hi  in  CW  SHALL be the upper edge-time bound, meaning the tick at which sel_lesser rises.
REQ-009 cfg_ready  out  1  SHALL indicate that the pending-config slot is empty.
REQ-010 sel_greater  out  1  SHALL be the filter's lower-bound reference edge.
REQ-011 sel_lesser  out  1  SHALL be the filter's upper-bound reference edge.
REQ-012 filt_grst  out  1  SHALL be the gamma reset driven to the filter and its input sources.
REQ-013 tick  out  CW  SHALL be the current tick within the window.
REQ-014 cycle_start  out  1  SHALL pulse for one cycle at tick 0 of every window.
REQ-015 gamma_count  out  16  SHALL count completed windows.
REQ-016 cfg_err  out  1  SHALL be a sticky flag for rejected configurations.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and FLUSH.
REQ-018 In IDLE: filt_grst=1, sel_*=0, tick=0; if en=1, the next state SHALL be RUN with tick=0.
REQ-019 In RUN: tick SHALL increment by 1 per cycle; at tick=GAMMA_CYCLE_WIDTH-1 the next state SHALL be FLUSH.
REQ-020 In RUN, sel_greater SHALL be registered high from the cycle in which tick==active_lo until the RUN state exits, and sel_lesser likewise from tick==active_hi; both SHALL be monotonic within a window.
REQ-021 FLUSH SHALL last exactly one cycle: filt_grst=1, sel_*=0, gamma_count increments with wrap 0xFFFF->0; next state SHALL be RUN if en=1, else IDLE.
REQ-022 Deasserting en during RUN SHALL NOT truncate the window; the sequencer SHALL return to IDLE after FLUSH.
REQ-023 Gamma-cycle period SHALL be GAMMA_CYCLE_WIDTH+1 cycles (RUN ticks plus FLUSH).
REQ-024 cycle_start SHALL be high exactly in the cycles where state==RUN and tick==0.
REQ-025 A configuration transfer SHALL occur on cfg_valid && cfg_ready and latch cfg_lo/cfg_hi into the pending slot; cfg_ready SHALL then be 0 until the slot is applied.
REQ-026 The pending slot SHALL be copied to active_lo/active_hi only in IDLE or FLUSH, so a window never changes bounds mid-window; cfg_ready SHALL return to 1 in the following cycle.
REQ-027 A pending config with lo>hi SHALL be discarded at apply time, active values SHALL remain unchanged, and cfg_err SHALL be set until grst.
REQ-028 lo==hi SHALL be legal, with both selects rising on the same tick.
REQ-029 hi=GAMMA_CYCLE_WIDTH-1 SHALL be legal, with sel_lesser high for exactly one cycle.
REQ-030 A transfer in the same cycle as an apply SHALL be impossible, because cfg_ready=0 while the slot is full; a new offer SHALL be accepted no earlier than the cycle after the apply.

Reset
REQ-031 While grst=1 the block SHALL force: state=IDLE, tick=0, gamma_count=0, cfg_err=0, pending slot empty (cfg_ready=1), active_lo=0, active_hi=GAMMA_CYCLE_WIDTH-1, filt_grst=1, sel_*=0, cycle_start=0.
REQ-032 grst asserted mid-RUN SHALL abort the window in the next cycle, with no gamma_count increment.

Structure
REQ-033 The state enum and a cfg struct {lo, hi} SHALL reside in shared package filter_pkg.
REQ-034 The tick counter with terminal-count output SHALL be the sub-module filter_tick_counter, instantiated once.

Verification (GAMMA_CYCLE_WIDTH=16)
REQ-035 Reset, then en=1 held -> cycle_start pulses every 17 cycles; gamma_count=3 after 51 cycles from first RUN.
REQ-036 cfg lo=4, hi=9 applied -> sel_greater rises at tick 4 and sel_lesser at tick 9; both drop in FLUSH.
REQ-037 cfg offered at tick 7 -> current window keeps old bounds, next window uses new bounds; cfg_ready low from tick 8 through FLUSH.
REQ-038 cfg lo=10, hi=3 -> cfg_err=1, bounds unchanged, cfg_ready returns to 1.
REQ-039 en dropped at tick 5 -> window runs to tick 15, FLUSH, IDLE with filt_grst held 1.
REQ-040 grst pulse at tick 12 -> next cycle IDLE, all outputs at reset values, gamma_count=0.

Source files
------------

// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared types for the filter window sequencer
// Purpose: sequencer state encoding, window-bound config record and its
//          legality check, shared by the sequencer top and its tick counter.
package filter_pkg;

  // Config storage width covers the widest tick (GAMMA_CYCLE_WIDTH up to 256).
  localparam int CFG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [CFG_W-1:0] lo;
    logic [CFG_W-1:0] hi;
  } cfg_t;

  // A window whose lower edge falls after its upper edge is meaningless.
  function automatic logic cfg_legal(input cfg_t c);
    return c.lo <= c.hi;
  endfunction

endpackage

// File: rtl/filter_tick_counter.sv
// rtl/filter_tick_counter.sv - window tick counter with terminal count
// Purpose: counts ticks within one gamma window.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears count
//   inc   - advance by one; when low the count returns to 0
//   count - current tick
//   tc    - high when count is the last tick of the window
module filter_tick_counter #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end else begin
      count <= '0;
    end
  end

  assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/filter_window_sequencer.sv
// rtl/filter_window_sequencer.sv - gamma-cycle window sequencer for a race-logic filter
// Purpose: runs back-to-back gamma windows of GAMMA_CYCLE_WIDTH ticks plus one
//          flush cycle, raising the lower/upper reference edges at configured
//          ticks, and applies new bounds only between windows.
// Ports:
//   aclk, grst          - clock, synchronous active-high reset
//   en                  - keep running windows
//   cfg_valid/cfg_ready - bound-config handshake, cfg_lo/cfg_hi are the edge ticks
//   sel_greater/lesser  - lower/upper bound reference edges
//   filt_grst           - gamma reset to the filter, high outside RUN
//   tick, cycle_start   - current tick, pulse at tick 0 of each window
//   gamma_count         - completed windows (wraps)
//   cfg_err             - sticky, set when an illegal config is discarded
module filter_window_sequencer
  import filter_pkg::*;
#(
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  localparam int CW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_lo,
  input  logic [CW-1:0] cfg_hi,
  output logic          cfg_ready,
  output logic          sel_greater,
  output logic          sel_lesser,
  output logic          filt_grst,
  output logic [CW-1:0] tick,
  output logic          cycle_start,
  output logic [15:0]   gamma_count,
  output logic          cfg_err
);

  state_t        state;
  state_t        state_next;
  cfg_t          active;
  cfg_t          active_next;
  cfg_t          pending;
  logic          pend_full;
  logic          apply;
  logic          tc;
  logic          tick_inc;
  logic [CW-1:0] tick_next;

  filter_tick_counter #(.WIDTH(GAMMA_CYCLE_WIDTH)) u_tick (
    .clk   (aclk),
    .rst   (grst),
    .inc   (tick_inc),
    .count (tick),
    .tc    (tc)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (en) state_next = ST_RUN;
      ST_RUN:   if (tc) state_next = ST_FLUSH;
      ST_FLUSH: state_next = en ? ST_RUN : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign tick_inc  = (state == ST_RUN) && !tc;
  assign tick_next = tick_inc ? tick + CW'(1) : '0;

  // Bounds change only between windows; the selects for the first tick of a
  // new window must already see the bounds being applied on the same edge.
  assign apply       = pend_full && (state != ST_RUN);
  assign active_next = (apply && cfg_legal(pending)) ? pending : active;
  assign cfg_ready   = !pend_full;

  always_ff @(posedge aclk) begin
    if (grst) begin
      state       <= ST_IDLE;
      pend_full   <= 1'b0;
      pending     <= '0;
      active.lo   <= '0;
      active.hi   <= CFG_W'(GAMMA_CYCLE_WIDTH - 1);
      cfg_err     <= 1'b0;
      gamma_count <= '0;
      filt_grst   <= 1'b1;
      sel_greater <= 1'b0;
      sel_lesser  <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      state  <= state_next;
      active <= active_next;
      if (apply) begin
        pend_full <= 1'b0;
        if (!cfg_legal(pending)) cfg_err <= 1'b1;
      end else if (cfg_valid && !pend_full) begin
        pend_full  <= 1'b1;
        pending.lo <= CFG_W'(cfg_lo);
        pending.hi <= CFG_W'(cfg_hi);
      end
      if (state == ST_FLUSH) gamma_count <= gamma_count + 16'd1;
      // Outputs are registered from next-cycle values so they line up with tick.
      filt_grst   <= (state_next != ST_RUN);
      sel_greater <= (state_next == ST_RUN) && (CFG_W'(tick_next) >= active_next.lo);
      sel_lesser  <= (state_next == ST_RUN) && (CFG_W'(tick_next) >= active_next.hi);
      cycle_start <= (state_next == ST_RUN) && (tick_next == '0);
    end
  end

endmodule
